// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: default sizing constants shared by the fetch queue slice.
// No ports; holds no parameter-dependent typedefs so every instance can be
// resized independently.
package fetch_queue_pkg;

    localparam int unsigned FQ_DEPTH_DEFAULT       = 4;
    localparam int unsigned FQ_INSTR_WIDTH_DEFAULT = 32;
    localparam int unsigned FQ_PC_WIDTH_DEFAULT    = 4;

endpackage : fetch_queue_pkg

// File: rtl/fifo_sync.sv
// fifo_sync: single-clock DEPTH x WIDTH FIFO with occupancy count and flush.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           empties the FIFO; wins over push and pop
//   push, wdata     write one word (caller guarantees not full)
//   pop             drop the head word (caller guarantees not empty)
//   rdata           head word (raw storage, meaningful only when count != 0)
//   count           occupancy 0..DEPTH
module fifo_sync #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign rdata = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; no reset needed, contents are qualified by count.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) mem[wr_ptr] <= wdata;
    end

endmodule : fifo_sync

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch PC, memory request issue and decode-side queue.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   o_mem_req, o_mem_addr         read request / address to instruction memory
//   i_mem_ready                   memory accepts the request this cycle
//   i_mem_data                    read data, one cycle after an accepted request
//   i_redirect, i_redirect_pc     taken branch: flush and refetch at target
//   o_valid, i_ready              decode handshake
//   o_instruction, o_pc           head entry (zero when nothing is presented)
// Build option: FETCH_QUEUE_BYPASS_EN lets a response reach the outputs in its
// arrival cycle when the queue is empty.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH = FQ_INSTR_WIDTH_DEFAULT,
    parameter int unsigned PC_WIDTH    = FQ_PC_WIDTH_DEFAULT,
    parameter int unsigned DEPTH       = FQ_DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   o_mem_req,
    output logic [PC_WIDTH-1:0]    o_mem_addr,
    input  logic                   i_mem_ready,
    input  logic [INSTR_WIDTH-1:0] i_mem_data,
    input  logic                   i_redirect,
    input  logic [PC_WIDTH-1:0]    i_redirect_pc,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [INSTR_WIDTH-1:0] o_instruction,
    output logic [PC_WIDTH-1:0]    o_pc
);

    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int unsigned WIDTH = INSTR_WIDTH + PC_WIDTH;

    logic [PC_WIDTH-1:0] fetch_pc;
    logic [PC_WIDTH-1:0] inflight_pc;
    logic                inflight;
    logic                kill;

    logic [CW-1:0]       count;
    logic [WIDTH-1:0]    head;
    logic                head_valid;
    logic                rsp_live;
    logic                accept;
    logic                push;
    logic                pop;

    // Issue only when the queue can absorb this request on top of any in-flight one.
    assign o_mem_req  = !rst && !i_redirect && ((count + CW'(inflight)) < CW'(DEPTH));
    assign o_mem_addr = fetch_pc;
    assign accept     = o_mem_req && i_mem_ready;

    // A response is dropped in reset, in a redirect cycle, or when marked killed.
    assign rsp_live   = !rst && !i_redirect && inflight && !kill;
    assign head_valid = !rst && (count != '0);

    // Decode-side view and FIFO control.
    always_comb begin
        push          = rsp_live;
        pop           = head_valid && i_ready && !i_redirect;
        o_valid       = head_valid;
        o_instruction = head_valid ? head[WIDTH-1 -: INSTR_WIDTH] : '0;
        o_pc          = head_valid ? head[PC_WIDTH-1:0] : '0;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (rsp_live && !head_valid) begin
            o_valid       = 1'b1;
            o_instruction = i_mem_data;
            o_pc          = inflight_pc;
            push          = !i_ready;
        end
`endif
    end

    // Fetch PC and in-flight tracking; redirect overrides the PC advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            kill        <= 1'b0;
        end else begin
            inflight <= accept;
            kill     <= i_redirect ? inflight : 1'b0;
            if (accept) begin
                fetch_pc    <= fetch_pc + PC_WIDTH'(1);
                inflight_pc <= fetch_pc;
            end
            if (i_redirect) fetch_pc <= i_redirect_pc;
        end
    end

    fifo_sync #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (i_redirect),
        .push  (push),
        .wdata ({i_mem_data, inflight_pc}),
        .pop   (pop),
        .rdata (head),
        .count (count)
    );

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table vectors, directed corner sequences and a randomized run
// of fetch_queue, all checked against a queue-based reference model.
module tb_fetch_queue;

    localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic [3:0]  pc;
    } ent_t;

    typedef struct {
        bit          rst;
        bit          ready;
        bit          mready;
        bit          e_valid;
        logic [3:0]  e_pc;
        logic [31:0] e_instr;
        bit          e_req;
        logic [3:0]  e_addr;
    } vec_t;

    bit          clk = 1'b0;
    logic        rst;
    logic        o_mem_req;
    logic [3:0]  o_mem_addr;
    logic        i_mem_ready;
    logic [31:0] i_mem_data;
    logic        i_redirect;
    logic [3:0]  i_redirect_pc;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_instruction;
    logic [3:0]  o_pc;

    int checks = 0;
    int errors = 0;

    // sampled DUT outputs of the latest cycle
    logic        s_valid, s_req;
    logic [3:0]  s_pc, s_addr;
    logic [31:0] s_instr;

    // reference model state
    ent_t        mq[$];
    bit          m_infl;
    bit          m_kill;
    logic [3:0]  m_infl_pc;
    logic [3:0]  m_fetch;
    logic [3:0]  exp_pc;
    logic [3:0]  delivered[$];

    always #5 clk = ~clk;

    fetch_queue #(
        .INSTR_WIDTH (32),
        .PC_WIDTH    (4),
        .DEPTH       (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .o_mem_req     (o_mem_req),
        .o_mem_addr    (o_mem_addr),
        .i_mem_ready   (i_mem_ready),
        .i_mem_data    (i_mem_data),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_instruction (o_instruction),
        .o_pc          (o_pc)
    );

    function automatic logic [31:0] mem_word(logic [3:0] pc);
        return 32'(pc) + 32'd100;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(bit r, bit redir, logic [3:0] rpc, bit rdy, bit mrdy);
        rst           = r;
        i_redirect    = redir;
        i_redirect_pc = rpc;
        i_ready       = rdy;
        i_mem_ready   = mrdy;
    endtask

    // One clock: sample at negedge, check against the model, advance the model,
    // then play the memory for the next cycle.
    task automatic cycle();
        bit   rsp, byp, fire, e_req, e_valid, macc;
        int   occ;
        ent_t head;
        @(negedge clk);
        s_valid = o_valid;
        s_pc    = o_pc;
        s_instr = o_instruction;
        s_req   = o_mem_req;
        s_addr  = o_mem_addr;

        rsp     = !rst && !i_redirect && m_infl && !m_kill;
        byp     = BYP && rsp && (mq.size() == 0);
        occ     = mq.size() + (m_infl ? 1 : 0);
        e_req   = !rst && !i_redirect && (occ < DEPTH);
        e_valid = !rst && ((mq.size() != 0) || byp);
        if (!e_valid)  head = '0;
        else if (byp)  head = '{instr: mem_word(m_infl_pc), pc: m_infl_pc};
        else           head = mq[0];

        chk("valid", 32'(s_valid), 32'(e_valid));
        chk("pc", 32'(s_pc), 32'(head.pc));
        chk("instr", s_instr, head.instr);
        chk("mem_req", 32'(s_req), 32'(e_req));
        if (e_req) chk("mem_addr", 32'(s_addr), 32'(m_fetch));

        fire = e_valid && i_ready && !i_redirect;
        if (fire) begin
            chk("stream_pc", 32'(s_pc), 32'(exp_pc));
            delivered.push_back(s_pc);
            exp_pc = exp_pc + 4'd1;
        end
        macc = e_req && i_mem_ready;

        if (rst) begin
            mq.delete();
            m_infl  = 1'b0;
            m_kill  = 1'b0;
            m_fetch = 4'd0;
            exp_pc  = 4'd0;
        end else if (i_redirect) begin
            mq.delete();
            m_kill  = m_infl;
            m_infl  = 1'b0;
            m_fetch = i_redirect_pc;
            exp_pc  = i_redirect_pc;
        end else begin
            if (fire && !byp) void'(mq.pop_front());
            if (rsp && !(byp && fire)) mq.push_back('{instr: mem_word(m_infl_pc), pc: m_infl_pc});
            m_kill = 1'b0;
            m_infl = macc;
            if (macc) begin
                m_infl_pc = m_fetch;
                m_fetch   = m_fetch + 4'd1;
            end
        end

        @(posedge clk);
        #1;
        i_mem_data = (s_req && i_mem_ready) ? mem_word(s_addr) : 32'($urandom());
    endtask

    function automatic vec_t mk(bit r, bit rdy, bit mrdy, bit v, logic [3:0] pc,
                                logic [31:0] ins, bit req, logic [3:0] addr);
        vec_t t;
        t.rst = r; t.ready = rdy; t.mready = mrdy;
        t.e_valid = v; t.e_pc = pc; t.e_instr = ins; t.e_req = req; t.e_addr = addr;
        return t;
    endfunction

    initial begin
        vec_t       tbl[$];
        logic [3:0] held[3];
        int         lat;
        int         bad;

        m_infl = 1'b0; m_kill = 1'b0; m_infl_pc = 4'd0; m_fetch = 4'd0; exp_pc = 4'd0;
        i_mem_data = 32'd0;
        set_in(1'b1, 1'b0, 4'd0, 1'b1, 1'b1);

        // reset, free run, mid-run reset, stall to full, release
        tbl.push_back(mk(1, 1, 1, 0, 0, 0,   0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0,   0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0,   1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0,   1, 1));
        tbl.push_back(mk(0, 1, 1, 1, 0, 100, 1, 2));
        tbl.push_back(mk(0, 1, 1, 1, 1, 101, 1, 3));
        tbl.push_back(mk(0, 1, 1, 1, 2, 102, 1, 4));
        tbl.push_back(mk(0, 1, 1, 1, 3, 103, 1, 5));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0,   0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0,   1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0,   1, 1));
        tbl.push_back(mk(0, 0, 1, 1, 0, 100, 1, 2));
        tbl.push_back(mk(0, 0, 1, 1, 0, 100, 1, 3));
        tbl.push_back(mk(0, 0, 1, 1, 0, 100, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 100, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 100, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 100, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 1, 101, 1, 4));
        tbl.push_back(mk(0, 1, 1, 1, 2, 102, 1, 5));
        tbl.push_back(mk(0, 1, 1, 1, 3, 103, 1, 6));
        tbl.push_back(mk(0, 1, 1, 1, 4, 104, 1, 7));

        for (int i = 0; i < tbl.size(); i++) begin
            set_in(tbl[i].rst, 1'b0, 4'd0, tbl[i].ready, tbl[i].mready);
            cycle();
`ifndef FETCH_QUEUE_BYPASS_EN
            chk($sformatf("tbl%0d_valid", i), 32'(s_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_pc", i), 32'(s_pc), 32'(tbl[i].e_pc));
            chk($sformatf("tbl%0d_instr", i), s_instr, tbl[i].e_instr);
            chk($sformatf("tbl%0d_req", i), 32'(s_req), 32'(tbl[i].e_req));
            if (tbl[i].e_req) chk($sformatf("tbl%0d_addr", i), 32'(s_addr), 32'(tbl[i].e_addr));
`endif
        end

        // redirect to 9 with 3 queued entries and one in flight, while stalled
        lat = BYP ? 2 : 3;
        set_in(1, 0, 0, 1, 1); cycle();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 0, 0, 1); cycle();
        end
        set_in(0, 1, 4'd9, 0, 1); cycle();
        chk("redir_no_req", 32'(s_req), 32'd0);
        delivered.delete();
        set_in(0, 0, 0, 1, 1);
        for (int k = 1; k <= 5; k++) begin
            cycle();
            if (k == 1) chk("redir_addr", 32'(s_addr), 32'd9);
            if (k == lat) begin
                chk("redir_lat_valid", 32'(s_valid), 32'd1);
                chk("redir_lat_pc", 32'(s_pc), 32'd9);
            end
        end
        chk("redir_first", (delivered.size() > 0) ? 32'(delivered[0]) : 32'd99, 32'd9);
        bad = 0;
        foreach (delivered[j]) if (delivered[j] >= 4'd4 && delivered[j] <= 4'd6) bad++;
        chk("redir_stale", 32'(bad), 32'd0);

        // memory ready toggling 1,0,0,1: address held until accepted
        set_in(1, 0, 0, 1, 1); cycle();
        delivered.delete();
        set_in(0, 0, 0, 1, 1); cycle();
        for (int k = 0; k < 3; k++) begin
            set_in(0, 0, 0, 1, (k == 2));
            cycle();
            held[k] = s_addr;
        end
        for (int k = 0; k < 3; k++) chk($sformatf("hold_addr%0d", k), 32'(held[k]), 32'd1);
        set_in(0, 0, 0, 1, 1);
        for (int k = 0; k < 6; k++) cycle();
        chk("hold_count", 32'(delivered.size() >= 4), 32'd1);
        foreach (delivered[j]) chk($sformatf("hold_seq%0d", j), 32'(delivered[j]), 32'(j));

        // PC wrap: redirect to 14, free run
        set_in(0, 1, 4'd14, 1, 1); cycle();
        delivered.delete();
        set_in(0, 0, 0, 1, 1);
        for (int k = 0; k < 7; k++) cycle();
        chk("wrap_count", 32'(delivered.size() >= 4), 32'd1);
        if (delivered.size() >= 4) begin
            chk("wrap0", 32'(delivered[0]), 32'd14);
            chk("wrap1", 32'(delivered[1]), 32'd15);
            chk("wrap2", 32'(delivered[2]), 32'd0);
            chk("wrap3", 32'(delivered[3]), 32'd1);
        end

        // one-cycle reset with the queue full
        set_in(0, 0, 0, 0, 1);
        for (int k = 0; k < 8; k++) cycle();
        chk("full_valid", 32'(s_valid), 32'd1);
        chk("full_no_req", 32'(s_req), 32'd0);
        set_in(1, 0, 0, 0, 1); cycle();
        chk("rst_req", 32'(s_req), 32'd0);
        set_in(0, 0, 0, 1, 1); cycle();
        chk("rst_valid", 32'(s_valid), 32'd0);
        chk("rst_pc", 32'(s_pc), 32'd0);
        chk("rst_refetch", 32'(s_addr), 32'd0);

        // randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            set_in(($urandom_range(0, 199) == 0),
                   ($urandom_range(0, 19) == 0),
                   4'($urandom()),
                   ($urandom_range(0, 9) < 7),
                   ($urandom_range(0, 9) < 7));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fetch_queue
